pipeline_ctrl: RTL and testbench

Stall/flush scheduler for the five-stage RV32I pipeline. It is the single source of load enables and bubble-insert flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It arbitrates between split instruction/data cache misses, load-use hazards detected against the ID-stage source registers, and EX-stage control-flow redirects. It also holds the one-cycle cache response pulses when the other port is still stalling, so no fetch or load data is lost or requested twice.

---
 rtl/pipeline_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush scheduler for a five-stage RV32I pipeline. It
//               produces the load enables and bubble flushes for the pipeline
//               registers. It holds cache response pulses until both ports
//               are ready, and it counts frozen cycles and inserted bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    output logic             imem_read,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             ex_redirect,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [31:0]      fetch_instr,
    output logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic [31:0]      i_buf_q, i_buf_d;
    logic [31:0]      d_buf_q, d_buf_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic             w_i_ready;
    logic             w_d_need;
    logic             w_d_ready;
    logic             w_advance;
    logic             w_lu_hazard;
    logic [1:0]       w_bubble_inc;
    logic [CNT_W:0]   w_bubble_sum;

    // Scheduling decision, output enables and next-state for held data and counters
    always_comb begin
        w_i_ready   = imem_resp | i_done_q;
        w_d_need    = exmem_mem_read | exmem_mem_write;
        w_d_ready   = !w_d_need | dmem_resp | d_done_q;
        w_advance   = w_i_ready & w_d_ready;
        w_lu_hazard = idex_mem_read && (idex_rd != 5'd0) &&
                      ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

        fetch_instr = imem_resp ? imem_rdata : i_buf_q;
        mem_rdata   = dmem_resp ? dmem_rdata : d_buf_q;

        load_pc      = 1'b0;
        load_ifid    = 1'b0;
        load_idex    = 1'b0;
        load_exmem   = 1'b0;
        load_memwb   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        i_done_d     = i_done_q;
        d_done_d     = d_done_q;
        i_buf_d      = i_buf_q;
        d_buf_d      = d_buf_q;
        stall_d      = stall_q;
        w_bubble_inc = 2'd0;

        if (!w_advance) begin
            // Frozen: latch whichever one-cycle response arrived so it is not lost
            if (imem_resp) begin
                i_done_d = 1'b1;
                i_buf_d  = imem_rdata;
            end
            if (dmem_resp) begin
                d_done_d = 1'b1;
                d_buf_d  = dmem_rdata;
            end
            if (stall_q != {CNT_W{1'b1}}) begin
                stall_d = stall_q + 1'b1;
            end
        end else begin
            d_done_d = 1'b0;
            if (ex_redirect) begin
                // Redirect outranks a load-use stall: the stalled ID instruction is squashed anyway
                load_pc      = 1'b1;
                load_ifid    = 1'b1;
                load_idex    = 1'b1;
                load_exmem   = 1'b1;
                load_memwb   = 1'b1;
                flush_ifid   = 1'b1;
                flush_idex   = 1'b1;
                i_done_d     = 1'b0;
                w_bubble_inc = 2'd2;
            end else if (w_lu_hazard) begin
                // Hold PC and IF/ID; keep the fetched word so it is not requested again
                load_idex    = 1'b1;
                flush_idex   = 1'b1;
                load_exmem   = 1'b1;
                load_memwb   = 1'b1;
                i_done_d     = 1'b1;
                i_buf_d      = fetch_instr;
                w_bubble_inc = 2'd1;
            end else begin
                load_pc    = 1'b1;
                load_ifid  = 1'b1;
                load_idex  = 1'b1;
                load_exmem = 1'b1;
                load_memwb = 1'b1;
                i_done_d   = 1'b0;
            end
        end

        // One extra bit catches the carry so the count saturates instead of wrapping
        w_bubble_sum = {1'b0, bubble_q} + {{(CNT_W-1){1'b0}}, w_bubble_inc};
        bubble_d     = w_bubble_sum[CNT_W] ? {CNT_W{1'b1}} : w_bubble_sum[CNT_W-1:0];

        imem_read  = !i_done_q;
        dmem_read  = exmem_mem_read & !d_done_q;
        dmem_write = exmem_mem_write & !d_done_q;

        // Nothing moves and nothing is requested while reset is held
        if (rst) begin
            load_pc    = 1'b0;
            load_ifid  = 1'b0;
            load_idex  = 1'b0;
            load_exmem = 1'b0;
            load_memwb = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
            imem_read  = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end

        stall_cycles = stall_q;
        bubble_count = bubble_q;
    end

    // State register: held-response bits, buffers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            i_buf_q  <= 32'd0;
            d_buf_q  <= 32'd0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            i_buf_q  <= i_buf_d;
            d_buf_q  <= d_buf_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl, with a second
//               narrow-counter instance used to reach counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp, dmem_resp;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        exmem_mem_read, exmem_mem_write;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, ex_redirect;

    logic        imem_read, dmem_read, dmem_write;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        flush_ifid, flush_idex;
    logic [31:0] fetch_instr, mem_rdata, stall_cycles, bubble_count;

    logic        s_imem_read, s_dmem_read, s_dmem_write;
    logic        s_load_pc, s_load_ifid, s_load_idex, s_load_exmem, s_load_memwb;
    logic        s_flush_ifid, s_flush_idex;
    logic [31:0] s_fetch_instr, s_mem_rdata;
    logic [2:0]  s_stall_cycles, s_bubble_count;

    logic [4:0]  loads;
    assign loads = {load_pc, load_ifid, load_idex, load_exmem, load_memwb};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .imem_read(imem_read),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .ex_redirect(ex_redirect),
        .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
        .load_exmem(load_exmem), .load_memwb(load_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fetch_instr(fetch_instr), .mem_rdata(mem_rdata),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    pipeline_ctrl #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .imem_read(s_imem_read),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(s_dmem_read), .dmem_write(s_dmem_write),
        .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .ex_redirect(ex_redirect),
        .load_pc(s_load_pc), .load_ifid(s_load_ifid), .load_idex(s_load_idex),
        .load_exmem(s_load_exmem), .load_memwb(s_load_memwb),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .fetch_instr(s_fetch_instr), .mem_rdata(s_mem_rdata),
        .stall_cycles(s_stall_cycles), .bubble_count(s_bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge and sampled at the falling edge
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_resp = 0; imem_rdata = 32'h0; dmem_resp = 0; dmem_rdata = 32'h0;
        exmem_mem_read = 0; exmem_mem_write = 0;
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0;
        idex_rd = 0; idex_mem_read = 0; ex_redirect = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        next();
        sample();
        chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
        chk("rst_loads", {27'd0, loads}, 32'd0);
        next();
        rst = 0;

        // First fetch after reset
        imem_resp = 1; imem_rdata = 32'h0000_0013;
        sample();
        chk("s1_imem_read", {31'd0, imem_read}, 32'd1);
        chk("s1_loads", {27'd0, loads}, 32'h1F);
        chk("s1_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk("s1_fetch", fetch_instr, 32'h0000_0013);
        chk("s1_stall", stall_cycles, 32'd0);
        chk("s1_bubble", bubble_count, 32'd0);
        next();

        // Load-use on rs2 = x5
        idle();
        imem_resp = 1; imem_rdata = 32'h00A0_0093;
        idex_mem_read = 1; idex_rd = 5'd5; ifid_uses_rs2 = 1; ifid_rs2 = 5'd5;
        sample();
        chk("lu_loads", {27'd0, loads}, 32'h07);
        chk("lu_flush", {30'd0, flush_ifid, flush_idex}, 32'd1);
        next();
        idle();
        sample();
        chk("lu_imem_read_held", {31'd0, imem_read}, 32'd0);
        chk("lu_fetch_buffered", fetch_instr, 32'h00A0_0093);
        chk("lu_bubble", bubble_count, 32'd1);
        chk("lu_resume_loads", {27'd0, loads}, 32'h1F);
        next();

        // Data-cache miss on a load; icache answers in cycle 2, dcache in cycle 6
        idle();
        exmem_mem_read = 1;
        sample();
        chk("dm_c1_loads", {27'd0, loads}, 32'd0);
        chk("dm_c1_dmem_read", {31'd0, dmem_read}, 32'd1);
        chk("dm_c1_stall", stall_cycles, 32'd0);
        next();
        imem_resp = 1; imem_rdata = 32'h1111_1111;
        sample();
        chk("dm_c2_loads", {27'd0, loads}, 32'd0);
        chk("dm_c2_imem_read", {31'd0, imem_read}, 32'd1);
        next();
        imem_resp = 0; imem_rdata = 32'h0;
        sample();
        chk("dm_c3_imem_read", {31'd0, imem_read}, 32'd0);
        chk("dm_c3_fetch", fetch_instr, 32'h1111_1111);
        next();
        sample();
        next();
        sample();
        chk("dm_c5_loads", {27'd0, loads}, 32'd0);
        next();
        dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
        sample();
        chk("dm_c6_loads", {27'd0, loads}, 32'h1F);
        chk("dm_c6_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("dm_c6_imem_read", {31'd0, imem_read}, 32'd0);
        chk("dm_c6_fetch", fetch_instr, 32'h1111_1111);
        chk("dm_c6_stall", stall_cycles, 32'd5);
        next();
        idle();
        imem_resp = 1; imem_rdata = 32'h0000_0013;
        sample();
        chk("dm_c7_rearm", {31'd0, imem_read}, 32'd1);
        chk("dm_c7_dmem_read", {31'd0, dmem_read}, 32'd0);
        chk("dm_c7_loads", {27'd0, loads}, 32'h1F);
        next();

        // Store: dcache answers first, its data stays buffered while the fetch is pending
        idle();
        exmem_mem_write = 1; dmem_resp = 1; dmem_rdata = 32'hCAFE_F00D;
        sample();
        chk("st_c1_dmem_write", {31'd0, dmem_write}, 32'd1);
        chk("st_c1_loads", {27'd0, loads}, 32'd0);
        next();
        dmem_resp = 0; dmem_rdata = 32'h0; imem_resp = 1; imem_rdata = 32'h0000_0013;
        sample();
        chk("st_c2_dmem_write", {31'd0, dmem_write}, 32'd0);
        chk("st_c2_rdata_buf", mem_rdata, 32'hCAFE_F00D);
        chk("st_c2_loads", {27'd0, loads}, 32'h1F);
        chk("st_c2_stall", stall_cycles, 32'd6);
        next();

        // Redirect together with a load-use hazard
        idle();
        imem_resp = 1; ex_redirect = 1;
        idex_mem_read = 1; idex_rd = 5'd7; ifid_uses_rs1 = 1; ifid_rs1 = 5'd7;
        sample();
        chk("rd_loads", {27'd0, loads}, 32'h1F);
        chk("rd_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
        next();

        // Destination x0 never causes a load-use bubble
        idle();
        imem_resp = 1;
        idex_mem_read = 1; idex_rd = 5'd0; ifid_uses_rs1 = 1; ifid_rs1 = 5'd0;
        sample();
        chk("x0_bubble_after_redirect", bubble_count, 32'd3);
        chk("x0_loads", {27'd0, loads}, 32'h1F);
        chk("x0_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        next();

        // Three frozen cycles: the 3-bit stall counter reaches 7 and holds
        idle();
        sample();
        next();
        sample();
        next();
        sample();
        next();
        imem_resp = 1;
        sample();
        chk("sat_stall_wide", stall_cycles, 32'd9);
        chk("sat_stall_small", {29'd0, s_stall_cycles}, 32'd7);
        chk("sat_bubble_x0", bubble_count, 32'd3);
        next();

        // Three redirects: the 3-bit bubble counter saturates on 7 + 2
        idle();
        imem_resp = 1; ex_redirect = 1;
        sample();
        next();
        sample();
        next();
        sample();
        next();

        // Miss in flight, then reset mid-miss
        idle();
        exmem_mem_read = 1; imem_resp = 1; imem_rdata = 32'h5555_AAAA;
        sample();
        chk("sat_bubble_wide", bubble_count, 32'd9);
        chk("sat_bubble_small", {29'd0, s_bubble_count}, 32'd7);
        chk("mm_loads", {27'd0, loads}, 32'd0);
        next();
        imem_resp = 0; imem_rdata = 32'h0;
        rst = 1;
        sample();
        chk("mm_rst_reqs", {29'd0, imem_read, dmem_read, dmem_write}, 32'd0);
        chk("mm_rst_loads", {27'd0, loads}, 32'd0);
        next();
        rst = 0;
        sample();
        chk("mm_post_stall", stall_cycles, 32'd0);
        chk("mm_post_bubble", bubble_count, 32'd0);
        chk("mm_post_imem_read", {31'd0, imem_read}, 32'd1);
        chk("mm_post_dmem_read", {31'd0, dmem_read}, 32'd1);
        chk("mm_post_fetch", fetch_instr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
